zeroriscy_prefetch_fifo: RTL
============================

Name: zeroriscy_prefetch_fifo

Overview:
- Parametrised instruction prefetch FIFO between the instruction memory interface and the IF stage.
- Buffers fetched 32-bit words with their addresses and bus-error flags.
- Realigns 16-bit compressed and unaligned 32-bit instructions.
- Exposes occupancy and a registered-only valid so the prefetch controller can throttle requests.

Parameters:
- DEPTH, 4, number of stored 32-bit entries; legal values are 3..16.
- CNT_W, $clog2(DEPTH+1), width of the occupancy output.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clear_i  in  1  flush all entries; takes effect at the next edge
- in_addr_i  in  32  address of the incoming word; valid alongside in_valid_i, or alone when storage is empty
- in_rdata_i  in  32  fetched word
- in_err_i  in  1  bus error for the incoming word
- in_valid_i  in  1  incoming word valid
- in_ready_o  out  1  FIFO can accept one more outstanding response
- out_valid_o  out  1  complete instruction available
- out_ready_i  in  1  IF stage consumes the instruction
- out_rdata_o  out  32  instruction, realigned; upper half is don't-care when compressed
- out_addr_o  out  32  PC of the instruction
- out_err_o  out  1  bus error on any word contributing to the instruction
- out_valid_stored_o  out  1  as out_valid_o, but computed from registers only
- count_o  out  CNT_W  number of valid stored entries

Behaviour:
- Reset: all entry valid bits are 0, addr/rdata/err are 0, count_o=0, out_valid_stored_o=0.
  - With storage empty, out_valid_o, out_rdata_o and out_addr_o fall through combinationally from the input port.
- Storage is a shift queue; entry 0 is the head.
  - An incoming word is written to the lowest invalid entry after any pop in the same cycle.
  - Push and pop in the same cycle keep count_o unchanged.
- in_ready_o = ~valid[DEPTH-2]. One slot is always reserved for a response already in flight.
  - in_valid_i while valid[DEPTH-1]=1 and clear_i=0 is illegal; flag it with an assertion.
- Head word is the stored entry 0 if valid, else the input word. The next word is entry 1 if valid, else the input word.
- out_addr_o = head address (stored, or in_addr_i when empty).
- Aligned PC (out_addr_o[1]=0):
  - out_rdata_o = head word.
  - out_valid_o = head valid.
  - out_err_o = head err.
- Unaligned PC (out_addr_o[1]=1):
  - out_rdata_o = {next[15:0], head[31:16]}.
  - If head[17:16]!=2'b11 (compressed): valid = head valid, err = head err.
  - Otherwise: valid = head valid AND next valid, err = head err OR next err.
- Pop on out_valid_o && out_ready_i:
  - Aligned, compressed: PC+2; the entry is kept.
  - Aligned, 32-bit: drop one entry; PC = word address + 4.
  - Unaligned, compressed: drop one entry; PC = word address + 4, aligned.
  - Unaligned, 32-bit: drop one entry; PC = word address + 4 with bit1 set.
  - Address arithmetic is 32-bit, wraps modulo 2^32.
- Error entry: if the head err=1, out_valid_o follows the head word alone, regardless of compressed decode, so the trap is taken without waiting for the next word.
- out_valid_stored_o uses the same rules with registered entries only; it is never combinationally dependent on in_* ports.
- clear_i: at the next edge all valid bits are 0 and count_o=0; a push or pop in the same cycle is discarded.
  - in_addr_i of the same cycle may already carry the new target.
  - clear_i has priority over everything except reset.
- Reset asserted mid-operation empties the FIFO immediately, asynchronously.

Optional Feature:
- Macro ZERORISCY_PREFETCH_RVC_EN.
- Defined: compressed and unaligned handling as above.
- Undefined:
  - Every instruction is treated as a 32-bit aligned word.
  - out_addr_o[1] is forced to 0 and each pop drops one entry with PC+4.
  - The unaligned mux and compressed decode are not built.

Test Plan:
- Reset, then push 0x00000013 @0x80, 0x00100093 @0x84, 0x00200113 @0x88 with out_ready_i=0:
  - count_o reaches 3 and in_ready_o falls after the 3rd push (DEPTH=4).
  - The three words pop in order at PC 0x80, 0x84, 0x88.
- Empty FIFO, in_valid_i=1 with 0x4501 @0x100, out_ready_i=1:
  - out_valid_o=1 in the same cycle, out_addr_o=0x100.
  - Next PC 0x102 with out_rdata_o[15:0]=0x0000 (upper half of the word).
- Words 0x00134501 @0x200 and 0xABCD0000 @0x204 (compressed 0x4501 at 0x200, 32-bit 0x00000013 straddling 0x202/0x204, compressed 0xABCD at 0x206; define RVC_EN):
  - Pops are 0x200 (0x4501), 0x202 (0x00000013), 0x206 (0xABCD).
  - out_valid_o at 0x202 is low until the word @0x204 arrives.
- Unaligned 32-bit instruction where the second word has in_err_i=1:
  - out_valid_o=1 and out_err_o=1.
- FIFO holding 3 entries, clear_i=1 with simultaneous in_valid_i:
  - Next cycle count_o=0 and out_valid_stored_o=0.
  - A new push @0x400 is delivered at out_addr_o=0x400.
- Back-to-back push and pop for 20 cycles:
  - count_o stays constant.
  - out_valid_stored_o never changes in response to in_valid_i within a cycle.

Source files
------------

// File: rtl/zeroriscy_prefetch_fifo.sv
// ---------------------------------------------------------------------------
// zeroriscy_prefetch_fifo
//
// Instruction prefetch FIFO between the instruction memory interface and the
// IF stage. Fetched 32-bit words are buffered with their addresses and bus
// error flags in a shift queue (entry 0 is the head). With compressed support
// enabled, 16-bit and unaligned 32-bit instructions are realigned on output.
//
// Optional feature macro: ZERORISCY_PREFETCH_RVC_EN
//   defined   : compressed decode and unaligned realignment are built
//   undefined : every instruction is an aligned 32-bit word, PC+4 per pop
//
// Parameters
//   DEPTH  number of stored 32-bit entries (3..16)
//   CNT_W  width of count_o
//
// Ports
//   clk                 clock
//   rst_n               asynchronous active-low reset
//   clear_i             flush all entries at the next edge
//   in_addr_i           address of incoming word (or new target when empty)
//   in_rdata_i          fetched word
//   in_err_i            bus error for the incoming word
//   in_valid_i          incoming word valid
//   in_ready_o          room for one more outstanding response
//   out_valid_o         complete instruction available
//   out_ready_i         IF stage consumes the instruction
//   out_rdata_o         realigned instruction
//   out_addr_o          PC of the instruction
//   out_err_o           bus error on any contributing word
//   out_valid_stored_o  out_valid_o computed from registers only
//   count_o             number of valid stored entries
// ---------------------------------------------------------------------------
module zeroriscy_prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic [31:0]      in_addr_i,
    input  logic [31:0]      in_rdata_i,
    input  logic             in_err_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_rdata_o,
    output logic [31:0]      out_addr_o,
    output logic             out_err_o,
    output logic             out_valid_stored_o,
    output logic [CNT_W-1:0] count_o
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] err_q, err_d;
    logic [31:0]      addr_q  [DEPTH];
    logic [31:0]      addr_d  [DEPTH];
    logic [31:0]      rdata_q [DEPTH];
    logic [31:0]      rdata_d [DEPTH];

    logic             head_valid;
    logic             head_err;
    logic [31:0]      head_rdata;
    logic [31:0]      head_addr;
    logic             pop;
    logic             drop;
    logic [31:0]      next_pc;
    logic [DEPTH-1:0] push_sel;

    // Storage is a thermometer code, so the lowest invalid entry is the one
    // whose lower neighbour is valid.
    assign push_sel = ~valid_q & {valid_q[DEPTH-2:0], 1'b1};

    // One slot stays free for a response that is already in flight.
    assign in_ready_o = ~valid_q[DEPTH-2];

    assign head_valid = valid_q[0] | in_valid_i;
    assign head_err   = valid_q[0] ? err_q[0]   : in_err_i;
    assign head_rdata = valid_q[0] ? rdata_q[0] : in_rdata_i;
    assign head_addr  = valid_q[0] ? addr_q[0]  : in_addr_i;

`ifdef ZERORISCY_PREFETCH_RVC_EN
    logic        next_valid;
    logic        next_err;
    logic [15:0] next_lo;
    logic        unaligned;
    logic        aligned_c;
    logic        unaligned_c;

    // With storage empty the input word is already the head, so it can only
    // serve as the second half when entry 0 holds the first half.
    assign next_valid  = valid_q[1] | (valid_q[0] & in_valid_i);
    assign next_err    = valid_q[1] ? err_q[1] : in_err_i;
    assign next_lo     = valid_q[1] ? rdata_q[1][15:0] : in_rdata_i[15:0];
    assign unaligned   = head_addr[1];
    assign aligned_c   = (head_rdata[1:0] != 2'b11);
    assign unaligned_c = (head_rdata[17:16] != 2'b11);
    assign out_addr_o  = head_addr;

    always_comb begin
        out_rdata_o = head_rdata;
        out_valid_o = head_valid;
        out_err_o   = head_err;
        if (unaligned) begin
            out_rdata_o = {next_lo, head_rdata[31:16]};
            // An erroring head is released alone so the trap is not held
            // back waiting for a second word.
            if (!unaligned_c && !head_err) begin
                out_valid_o = head_valid & next_valid;
                out_err_o   = head_err | next_err;
            end
        end
    end

    assign out_valid_stored_o = valid_q[0] &
                                (~addr_q[0][1] | (rdata_q[0][17:16] != 2'b11) |
                                 err_q[0] | valid_q[1]);

    // Aligned compressed consumes only the low half: keep the entry.
    assign drop = unaligned | ~aligned_c;

    always_comb begin
        if (!drop) begin
            next_pc = head_addr + 32'd2;
        end else begin
            next_pc = {head_addr[31:2] + 30'd1, unaligned & ~unaligned_c, 1'b0};
        end
    end
`else
    assign out_addr_o         = {head_addr[31:2], head_addr[1] & 1'b0, head_addr[0]};
    assign out_rdata_o        = head_rdata;
    assign out_valid_o        = head_valid;
    assign out_err_o          = head_err;
    assign out_valid_stored_o = valid_q[0];
    assign drop               = 1'b1;
    assign next_pc            = {head_addr[31:2] + 30'd1, 2'b00};
`endif

    assign pop = out_valid_o & out_ready_i;

    // Push into the lowest free slot, then shift out the consumed entry; the
    // new head always receives the computed PC.
    always_comb begin
        valid_d = valid_q;
        err_d   = err_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (in_valid_i && push_sel[i]) begin
                valid_d[i] = 1'b1;
                err_d[i]   = in_err_i;
                addr_d[i]  = in_addr_i;
                rdata_d[i] = in_rdata_i;
            end
        end
        if (pop && drop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                valid_d[i] = valid_d[i+1];
                err_d[i]   = err_d[i+1];
                addr_d[i]  = addr_d[i+1];
                rdata_d[i] = rdata_d[i+1];
            end
            valid_d[DEPTH-1] = 1'b0;
        end
        if (pop) begin
            addr_d[0] = next_pc;
        end
        if (clear_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                rdata_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        count_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_o = count_o + CNT_W'(valid_q[i]);
        end
    end

    // A response arriving with every slot occupied would be lost.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(in_valid_i && valid_q[DEPTH-1] && !clear_i));

endmodule
